// File: rtl/heap_array_reader.sv
// Streams a contiguous slice of one heap array over a valid/ready channel using a 2-entry skid buffer.
// Optional HEAP_READER_BOUNDS_CHECK_EN inserts a SIZE state that also clips to the live array length.
module heap_array_reader #(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NArea              = 10,
  parameter int unsigned NArrays            = 2,
  parameter int unsigned NHeap              = 20,
  parameter int unsigned AddrWidth          = 8
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          start,
  output logic                          startReady,
  input  logic [MemoryElementWidth-1:0] array,
  input  logic [MemoryElementWidth-1:0] offset,
  input  logic [MemoryElementWidth-1:0] count,
  output logic                          heapRe,
  output logic [AddrWidth-1:0]          heapAddr,
  input  logic [MemoryElementWidth-1:0] heapData,
  output logic [MemoryElementWidth-1:0] sizeAddr,
  input  logic [MemoryElementWidth-1:0] sizeData,
  output logic [MemoryElementWidth-1:0] outData,
  output logic                          outValid,
  input  logic                          outReady,
  output logic                          outLast,
  output logic                          done,
  output logic                          error
);

  localparam int unsigned W   = MemoryElementWidth;
  localparam int unsigned AW1 = AddrWidth + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
`ifdef HEAP_READER_BOUNDS_CHECK_EN
  localparam logic [1:0] S_SIZE   = 2'd1;
`endif
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]   state_q, state_d;
  logic         start_ready_q, start_ready_d;
  logic [W-1:0] arr_q, arr_d, off_q, off_d;
  logic [W-1:0] issue_left_q, issue_left_d, issue_idx_q, issue_idx_d;
  logic [W-1:0] beats_left_q, beats_left_d;
  logic         ret_valid_q, ret_valid_d, ret_last_q, ret_last_d;
  logic [W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic         last0_q, last0_d, last1_q, last1_d;
  logic [1:0]   cnt_q, cnt_d, cnt_pop;
  logic         done_q, done_d, error_q, error_d;
  logic [W-1:0] size_addr_q, size_addr_d;

  logic [W-1:0]   avail, n_req;
  logic           xfer, issue, in_heap;
  logic [2:0]     occupancy;
  logic [AW1-1:0] addr_full;

  // Address of the next element to issue, kept one bit wider than the heap port.
  assign addr_full = AW1'(arr_q) * AW1'(NArea) + AW1'(off_q) + AW1'(issue_idx_q);
  assign in_heap   = addr_full < AW1'(NHeap);

  // Reads are issued combinationally so a beat that leaves this cycle frees a slot immediately,
  // which is what lets two buffer entries sustain one beat per cycle.
  assign heapRe     = issue && in_heap;
  assign heapAddr   = heapRe ? addr_full[AddrWidth-1:0] : '0;
  assign startReady = start_ready_q;
  assign outValid   = cnt_q != 2'd0;
  assign outData    = buf0_q;
  assign outLast    = last0_q && outValid;
  assign done       = done_q;
  assign error      = error_q;
  assign sizeAddr   = size_addr_q;

`ifndef HEAP_READER_BOUNDS_CHECK_EN
  logic unused_size;
  assign unused_size = ^sizeData;
`endif

  always_comb begin
    state_d      = state_q;
    arr_d        = arr_q;
    off_d        = off_q;
    issue_left_d = issue_left_q;
    issue_idx_d  = issue_idx_q;
    beats_left_d = beats_left_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    last0_d      = last0_q;
    last1_d      = last1_q;
    error_d      = error_q;
    size_addr_d  = size_addr_q;
    avail        = '0;
    n_req        = '0;

    xfer      = outValid && outReady;
    occupancy = 3'(cnt_q) + 3'(ret_valid_q) - 3'(xfer);
    issue     = (state_q == S_STREAM) && (issue_left_q != '0) && (occupancy < 3'd2);

    ret_valid_d = issue;
    ret_last_d  = issue && (issue_left_q == W'(1));
    if (issue) begin
      issue_left_d = issue_left_q - W'(1);
      issue_idx_d  = issue_idx_q + W'(1);
    end

    // Pop the head first, then a returning read lands in the first free entry.
    cnt_pop = cnt_q - 2'(xfer);
    if (xfer) begin
      buf0_d       = buf1_q;
      last0_d      = last1_q;
      beats_left_d = beats_left_q - W'(1);
    end
    if (ret_valid_q) begin
      if (cnt_pop == 2'd0) begin
        buf0_d  = heapData;
        last0_d = ret_last_q;
      end else begin
        buf1_d  = heapData;
        last1_d = ret_last_q;
      end
    end
    cnt_d = cnt_pop + 2'(ret_valid_q);

    case (state_q)
      S_IDLE: begin
        if (start && start_ready_q) begin
          arr_d       = array;
          off_d       = offset;
          issue_idx_d = '0;
          avail       = (offset >= W'(NArea)) ? '0 : W'(NArea) - offset;
          n_req       = (count < avail) ? count : avail;
`ifdef HEAP_READER_BOUNDS_CHECK_EN
          size_addr_d = array;
`endif
          if (array >= W'(NArrays)) begin
            n_req   = '0;
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            error_d = n_req < count;
`ifdef HEAP_READER_BOUNDS_CHECK_EN
            state_d = S_SIZE;
`else
            state_d = S_STREAM;
`endif
          end
          issue_left_d = n_req;
          beats_left_d = n_req;
        end
      end
`ifdef HEAP_READER_BOUNDS_CHECK_EN
      S_SIZE: begin
        avail = (off_q >= sizeData) ? '0 : sizeData - off_q;
        if (avail < issue_left_q) begin
          issue_left_d = avail;
          beats_left_d = avail;
          error_d      = 1'b1;
        end
        state_d = S_STREAM;
      end
`endif
      S_STREAM: begin
        if ((beats_left_q == '0) || (xfer && (beats_left_q == W'(1)))) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d        = state_d == S_DONE;
    start_ready_d = state_d == S_IDLE;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      start_ready_q <= 1'b1;
      arr_q         <= '0;
      off_q         <= '0;
      issue_left_q  <= '0;
      issue_idx_q   <= '0;
      beats_left_q  <= '0;
      ret_valid_q   <= 1'b0;
      ret_last_q    <= 1'b0;
      buf0_q        <= '0;
      buf1_q        <= '0;
      last0_q       <= 1'b0;
      last1_q       <= 1'b0;
      cnt_q         <= 2'd0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      size_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      start_ready_q <= start_ready_d;
      arr_q         <= arr_d;
      off_q         <= off_d;
      issue_left_q  <= issue_left_d;
      issue_idx_q   <= issue_idx_d;
      beats_left_q  <= beats_left_d;
      ret_valid_q   <= ret_valid_d;
      ret_last_q    <= ret_last_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      last0_q       <= last0_d;
      last1_q       <= last1_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      error_q       <= error_d;
      size_addr_q   <= size_addr_d;
    end
  end

endmodule

// File: tb/tb_heap_array_reader.sv
// Directed, table-driven bench for heap_array_reader with a 1-cycle synchronous heap model.
module tb_heap_array_reader;

  typedef struct {
    logic [11:0] arr;
    logic [11:0] off;
    logic [11:0] cnt;
    int          mode;
    int          n;
    int          base;
    logic        err;
    logic [11:0] size1;
  } vec_t;

`ifdef HEAP_READER_BOUNDS_CHECK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clock, resetN, start, startReady;
  logic [11:0] array, offset, count;
  logic        heapRe;
  logic [7:0]  heapAddr;
  logic [11:0] heapData, sizeAddr, sizeData, outData;
  logic        outValid, outReady, outLast, done, error;

  logic [11:0] heap_mem [0:255];
  logic [11:0] size1;
  int          n_cmp, n_bad;
  vec_t        vecs [11];

  heap_array_reader dut (
    .clock(clock), .resetN(resetN), .start(start), .startReady(startReady),
    .array(array), .offset(offset), .count(count),
    .heapRe(heapRe), .heapAddr(heapAddr), .heapData(heapData),
    .sizeAddr(sizeAddr), .sizeData(sizeData),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .outLast(outLast), .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (heapRe) heapData <= heap_mem[heapAddr];
  assign sizeData = (sizeAddr == 12'd1) ? size1 : 12'd10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      2:       return (c % 3) != 1;
      default: return c >= 6;
    endcase
  endfunction

  // Runs one command from IDLE; keeps start high with junk fields while busy.
  task automatic run_cmd(input int idx, input vec_t v);
    int          beats, first_cyc, last_cyc, done_cyc;
    logic [11:0] held;
    bit          holding;
    beats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; holding = 0; held = '0;
    chk($sformatf("v%0d start_ready", idx), 32'(startReady), 32'd1);
    size1 = v.size1;
    start = 1'b1; array = v.arr; offset = v.off; count = v.cnt;
    @(posedge clock); #1;
    array = 12'd0; offset = 12'd0; count = 12'd1;
    for (int c = 0; c < 100; c++) begin
      outReady = ready_for(v.mode, c);
      @(negedge clock);
      if (outValid) begin
        if (first_cyc < 0) first_cyc = c;
        if (holding) chk($sformatf("v%0d hold c%0d", idx, c), 32'(outData), 32'(held));
        if (outReady) begin
          if (beats < v.n) begin
            chk($sformatf("v%0d data b%0d", idx, beats), 32'(outData), 32'(heap_mem[8'(v.base + beats)]));
            chk($sformatf("v%0d last b%0d", idx, beats), 32'(outLast), 32'(beats == v.n - 1));
          end
          beats++;
          last_cyc = c;
          holding  = 0;
        end else begin
          holding = 1;
          held    = outData;
        end
      end
      if (done) begin
        done_cyc = c;
        start    = 1'b0;
        break;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    chk($sformatf("v%0d done_seen", idx), 32'(done_cyc >= 0), 32'd1);
    chk($sformatf("v%0d beats", idx), 32'(beats), 32'(v.n));
    chk($sformatf("v%0d error", idx), 32'(error), 32'(v.err));
    if (v.n > 0 && v.mode == 0) begin
      chk($sformatf("v%0d latency", idx), 32'(first_cyc), 32'(LAT));
      chk($sformatf("v%0d burst", idx), 32'(last_cyc - first_cyc), 32'(v.n - 1));
      chk($sformatf("v%0d done_cyc", idx), 32'(done_cyc), 32'(last_cyc + 1));
    end
    @(posedge clock); #1;
    chk($sformatf("v%0d done_pulse", idx), 32'(done), 32'd0);
    chk($sformatf("v%0d ready_back", idx), 32'(startReady), 32'd1);
    chk($sformatf("v%0d error_sticky", idx), 32'(error), 32'(v.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a1 [10];
    int          seen;
    vec_t        rv;
    a1 = '{12'd100, 12'd101, 12'd4, 12'd5, 12'd6, 12'd105, 12'd106, 12'd107, 12'd108, 12'd109};
    for (int i = 0; i < 256; i++) heap_mem[i] = 12'd0;
    for (int i = 0; i < 10; i++) begin
      heap_mem[i]      = 12'(i);
      heap_mem[10 + i] = a1[i];
    end
    n_cmp = 0; n_bad = 0;

    //          arr    off       cnt       mode n   base err   size1
    vecs[0]  = '{12'd1, 12'd0,    12'd10,   0,   10, 10,  1'b0, 12'd10};
    vecs[1]  = '{12'd1, 12'd0,    12'd10,   1,   10, 10,  1'b0, 12'd10};
    vecs[2]  = '{12'd0, 12'd3,    12'd0,    0,   0,  0,   1'b0, 12'd10};
    vecs[3]  = '{12'd1, 12'd8,    12'd5,    0,   2,  18,  1'b1, 12'd10};
    vecs[4]  = '{12'd2, 12'd0,    12'd1,    0,   0,  0,   1'b1, 12'd10};
    vecs[5]  = '{12'd1, 12'd3,    12'd4,    3,   4,  13,  1'b0, 12'd10};
    vecs[6]  = '{12'd0, 12'd9,    12'd3,    2,   1,  9,   1'b1, 12'd10};
    vecs[7]  = '{12'd0, 12'hFFF,  12'd1,    0,   0,  0,   1'b1, 12'd10};
    vecs[8]  = '{12'd1, 12'd0,    12'd10,   0,   10, 10,  1'b0, 12'd3};
    vecs[9]  = '{12'd0, 12'd0,    12'd2,    1,   2,  0,   1'b0, 12'd10};
    vecs[10] = '{12'd0, 12'd0,    12'hFFF,  2,   10, 0,   1'b1, 12'd10};
`ifdef HEAP_READER_BOUNDS_CHECK_EN
    vecs[8].n   = 3;
    vecs[8].err = 1'b1;
`endif

    resetN = 1'b0; start = 1'b0; array = '0; offset = '0; count = '0;
    outReady = 1'b0; heapData = '0; size1 = 12'd10;
    #12;
    chk("rst startReady", 32'(startReady), 32'd1);
    chk("rst outValid", 32'(outValid), 32'd0);
    chk("rst outLast", 32'(outLast), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    chk("rst heapRe", 32'(heapRe), 32'd0);
    chk("rst heapAddr", 32'(heapAddr), 32'd0);
    chk("rst sizeAddr", 32'(sizeAddr), 32'd0);
    resetN = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 11; i++) run_cmd(i, vecs[i]);

    // Reset while beat 4 of the array-1 stream is on the output.
    size1 = 12'd10; outReady = 1'b1;
    start = 1'b1; array = 12'd1; offset = 12'd0; count = 12'd10;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (outValid) seen++;
      if (seen == 4) break;
      @(posedge clock); #1;
    end
    chk("mid beat4", 32'(outData), 32'd5);
    #1 resetN = 1'b0;
    #1;
    chk("mid outValid", 32'(outValid), 32'd0);
    chk("mid done", 32'(done), 32'd0);
    chk("mid startReady", 32'(startReady), 32'd1);
    chk("mid heapRe", 32'(heapRe), 32'd0);
    #1 resetN = 1'b1;
    @(posedge clock); #1;
    rv = '{12'd0, 12'd0, 12'd2, 0, 2, 0, 1'b0, 12'd10};
    run_cmd(11, rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
